// File: rtl/extend_arbiter.sv
// ============================================================================
// Module   : extend_arbiter
// Function : Round-robin share of one 12->32 bit sign/zero immediate extender
//            between two requesters, with a registered valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module extend_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [11:0] req0_imm,
  input  logic        req0_signed,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [11:0] req1_imm,
  input  logic        req1_signed,
  output logic        req1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_id,
  output logic [15:0] conflict_count
);

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q,  out_data_d;
  logic        out_id_q,    out_id_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] conflict_q,  conflict_d;

  logic        w_can_accept;
  logic        w_any_valid;
  logic        w_both_valid;
  logic        w_grant;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_xfer;
  logic [11:0] w_sel_imm;
  logic        w_sel_signed;
  logic [31:0] w_ext;

  assign w_can_accept = !out_valid_q || out_ready;
  assign w_any_valid  = req0_valid || req1_valid;
  assign w_both_valid = req0_valid && req1_valid;

  // On a tie the requester that did not win last time gets the grant.
  assign w_grant  = w_both_valid ? ~last_grant_q : req1_valid;

  assign w_ready0 = w_can_accept && w_any_valid && (w_grant == 1'b0) && !reset;
  assign w_ready1 = w_can_accept && w_any_valid && (w_grant == 1'b1) && !reset;
  assign w_xfer   = (req0_valid && w_ready0) || (req1_valid && w_ready1);

  assign w_sel_imm    = w_grant ? req1_imm    : req0_imm;
  assign w_sel_signed = w_grant ? req1_signed : req0_signed;
  assign w_ext        = w_sel_signed ? {{20{w_sel_imm[11]}}, w_sel_imm}
                                     : {20'h00000, w_sel_imm};

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    last_grant_d = last_grant_q;
    conflict_d   = conflict_q;

    if (w_xfer) begin
      out_valid_d  = 1'b1;
      out_data_d   = w_ext;
      out_id_d     = w_grant;
      last_grant_d = w_grant;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end

    if (w_both_valid && w_can_accept && (conflict_q != C_CNT_MAX)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'h0;
      out_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      conflict_q   <= 16'h0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      last_grant_q <= last_grant_d;
      conflict_q   <= conflict_d;
    end
  end

  assign req0_ready     = w_ready0;
  assign req1_ready     = w_ready1;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_id         = out_id_q;
  assign conflict_count = conflict_q;

endmodule

`default_nettype wire

// File: tb/tb_extend_arbiter.sv
// ============================================================================
// Module   : tb_extend_arbiter
// Function : Directed self-checking bench for extend_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_extend_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic [11:0] req0_imm;
  logic        req0_signed;
  logic        req0_ready;
  logic        req1_valid;
  logic [11:0] req1_imm;
  logic        req1_signed;
  logic        req1_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_id;
  logic [15:0] conflict_count;

  int checks = 0;
  int errors = 0;

  extend_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_imm       (req0_imm),
    .req0_signed    (req0_signed),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_imm       (req1_imm),
    .req1_signed    (req1_signed),
    .req1_ready     (req1_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_id         (out_id),
    .conflict_count (conflict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1;
    req0_valid = 1'b1; req0_imm = 12'h800; req0_signed = 1'b1;
    req1_valid = 1'b0; req1_imm = 12'h000; req1_signed = 1'b0;
    tick(); tick();
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data",  out_data, 32'h0);
    chk("rst_out_id",    {31'h0, out_id}, 32'h0);
    chk("rst_count",     {16'h0, conflict_count}, 32'h0);
    chk("rst_ready0",    {31'h0, req0_ready}, 32'h0);

    // Requester 0 alone, sign-extended negative value
    reset = 1'b0;
    #1;
    chk("r0_ready0", {31'h0, req0_ready}, 32'h1);
    chk("r0_ready1", {31'h0, req1_ready}, 32'h0);
    tick();
    req0_valid = 1'b0;
    chk("r0_valid", {31'h0, out_valid}, 32'h1);
    chk("r0_data",  out_data, 32'hFFFFF800);
    chk("r0_id",    {31'h0, out_id}, 32'h0);

    // Requester 1 alone: zero-extend, then sign-extend a positive value
    req1_valid = 1'b1; req1_imm = 12'h800; req1_signed = 1'b0;
    #1;
    chk("r1_ready1", {31'h0, req1_ready}, 32'h1);
    tick();
    chk("r1_zext_data", out_data, 32'h00000800);
    chk("r1_zext_id",   {31'h0, out_id}, 32'h1);
    req1_imm = 12'h7FF; req1_signed = 1'b1;
    tick();
    chk("r1_sext_data", out_data, 32'h000007FF);
    req1_valid = 1'b0;
    #1;
    chk("idle_readies", {30'h0, req0_ready, req1_ready}, 32'h0);
    tick();
    chk("drain_valid", {31'h0, out_valid}, 32'h0);
    chk("drain_data",  out_data, 32'h000007FF);
    chk("drain_id",    {31'h0, out_id}, 32'h1);

    // Fairness from reset with both requesters held valid
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_imm = 12'h001; req0_signed = 1'b0;
    req1_valid = 1'b1; req1_imm = 12'h002; req1_signed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fair_ready0", {31'h0, req0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("fair_ready1", {31'h0, req1_ready}, (i % 2 == 0) ? 32'h0 : 32'h1);
      tick();
      chk("fair_id", {31'h0, out_id}, (i % 2 == 0) ? 32'h0 : 32'h1);
    end
    chk("fair_count", {16'h0, conflict_count}, 32'd4);

    // Stall: output held, no readies, no counting
    out_ready = 1'b0;
    #1;
    chk("stall_readies", {30'h0, req0_ready, req1_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data",  out_data, 32'h00000002);
      chk("stall_valid", {31'h0, out_valid}, 32'h1);
      chk("stall_count", {16'h0, conflict_count}, 32'd4);
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready0", {31'h0, req0_ready}, 32'h1);
    tick();
    chk("release_valid", {31'h0, out_valid}, 32'h1);
    chk("release_id",    {31'h0, out_id}, 32'h0);
    chk("release_data",  out_data, 32'h00000001);
    chk("release_count", {16'h0, conflict_count}, 32'd5);

    // Run the counter up to one below saturation, then past it
    for (int i = 0; i < 65529; i++) begin
      tick();
    end
    chk("sat_pre", {16'h0, conflict_count}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_hold", {16'h0, conflict_count}, 32'h0000FFFF);
    end

    // Reset while an output is pending and requests are valid
    chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_readies", {30'h0, req0_ready, req1_ready}, 32'h0);
    tick();
    chk("midrst_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_data",  out_data, 32'h0);
    chk("midrst_count", {16'h0, conflict_count}, 32'h0);
    chk("midrst_readies2", {30'h0, req0_ready, req1_ready}, 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready0", {31'h0, req0_ready}, 32'h1);
    chk("post_rst_ready1", {31'h0, req1_ready}, 32'h0);
    tick();
    chk("post_rst_id", {31'h0, out_id}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
